// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard and sequencing controller for a 5-stage 8-bit pipeline.
//             Tracks the destinations in flight after ID and derives the
//             stall, squash, drain and EX forwarding controls from them.
//  Ports    : clk, reset          - clock, asynchronous active-high reset
//             id_*                - instruction currently in ID
//             ex_branch_taken     - branch in EX resolved taken
//             pc_we, ifid_we      - fetch / IF-ID load enables (comb)
//             ifid_flush          - clear IF/ID to NOP (comb)
//             idex_bubble         - load NOP into ID/EX (comb)
//             fwd_a, fwd_b        - EX operand selects (registered)
//             halted              - pipeline stopped after HALT (registered)
//             stall_count         - saturating load-use stall count
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter logic [3:0] OP_LOAD = 4'h8,
  parameter logic [3:0] OP_HALT = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_ra,
  input  logic [3:0] id_rb,
  input  logic [3:0] id_rw,
  input  logic       id_uses_a,
  input  logic       id_uses_b,
  input  logic       id_writes,
  input  logic       ex_branch_taken,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted,
  output logic [7:0] stall_count
);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_DRAIN  = 2'd1;
  localparam logic [1:0] c_ST_HALTED = 2'd2;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_EXM = 2'b01;
  localparam logic [1:0] c_FWD_MWB = 2'b10;

  logic [1:0] state_q, state_d;

  // EX and MEM slot records. A WB slot record would be dead logic: a WB
  // producer needs no forwarding (regfile writes before it reads), and the
  // drain check looks at the slot contents after the edge, where WB <= MEM.
  logic       ex_v_q, ex_v_d;
  logic [3:0] ex_rw_q, ex_rw_d;
  logic       ex_wr_q, ex_wr_d;
  logic       ex_ld_q, ex_ld_d;
  logic       mem_v_q, mem_v_d;
  logic [3:0] mem_rw_q, mem_rw_d;
  logic       mem_wr_q, mem_wr_d;

  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic [7:0] stall_q, stall_d;

  logic w_lu_hazard;
  logic w_issue;
  logic w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;

  assign w_ex_hit_a  = ex_v_q  && ex_wr_q  && (ex_rw_q  == id_ra);
  assign w_ex_hit_b  = ex_v_q  && ex_wr_q  && (ex_rw_q  == id_rb);
  assign w_mem_hit_a = mem_v_q && mem_wr_q && (mem_rw_q == id_ra);
  assign w_mem_hit_b = mem_v_q && mem_wr_q && (mem_rw_q == id_rb);

  // A load's data is only ready at the end of MEM, so a consumer right
  // behind it must wait one cycle and then pick the value up from MEM/WB.
  assign w_lu_hazard = id_valid && ex_ld_q &&
                       ((w_ex_hit_a && id_uses_a) || (w_ex_hit_b && id_uses_b));

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    stall_d     = stall_q;

    case (state_q)
      c_ST_RUN: begin
        if (ex_branch_taken) begin
          // Squash the wrong-path instruction in ID; fetch the target.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (w_lu_hazard) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          if (stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
          end
        end else if (id_valid && (id_opcode == OP_HALT)) begin
          state_d = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        // After this edge EX gets a bubble, MEM <= EX and WB <= MEM.
        if (!ex_v_q && !mem_v_q) begin
          state_d = c_ST_HALTED;
        end
      end
      default: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        state_d     = c_ST_HALTED;
      end
    endcase

    w_issue = id_valid && !idex_bubble;

    ex_v_d   = w_issue;
    ex_rw_d  = w_issue ? id_rw : 4'd0;
    ex_wr_d  = w_issue && id_writes;
    ex_ld_d  = w_issue && (id_opcode == OP_LOAD);
    mem_v_d  = ex_v_q;
    mem_rw_d = ex_rw_q;
    mem_wr_d = ex_wr_q;

    // Selects travel with the issued instruction into EX; EX/MEM wins.
    fwd_a_d = c_FWD_RF;
    fwd_b_d = c_FWD_RF;
    if (w_issue && id_uses_a) begin
      if (w_ex_hit_a) begin
        fwd_a_d = c_FWD_EXM;
      end else if (w_mem_hit_a) begin
        fwd_a_d = c_FWD_MWB;
      end
    end
    if (w_issue && id_uses_b) begin
      if (w_ex_hit_b) begin
        fwd_b_d = c_FWD_EXM;
      end else if (w_mem_hit_b) begin
        fwd_b_d = c_FWD_MWB;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= c_ST_RUN;
      ex_v_q   <= 1'b0;
      ex_rw_q  <= 4'd0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rw_q <= 4'd0;
      mem_wr_q <= 1'b0;
      fwd_a_q  <= c_FWD_RF;
      fwd_b_q  <= c_FWD_RF;
      stall_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      ex_v_q   <= ex_v_d;
      ex_rw_q  <= ex_rw_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_rw_q <= mem_rw_d;
      mem_wr_q <= mem_wr_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      stall_q  <= stall_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign halted      = (state_q == c_ST_HALTED);
  assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed, table-driven self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_opcode, id_ra, id_rb, id_rw;
  logic       id_uses_a, id_uses_b, id_writes, ex_branch_taken;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.OP_LOAD(4'h8), .OP_HALT(4'hF)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ra(id_ra), .id_rb(id_rb), .id_rw(id_rw), .id_uses_a(id_uses_a),
    .id_uses_b(id_uses_b), .id_writes(id_writes),
    .ex_branch_taken(ex_branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] op, ra, rb, rw;
    logic       ua, ub, wr, br;
    logic       e_pc, e_ifid, e_fl, e_bub;   // combinational, before the edge
    logic [1:0] e_fa, e_fb;                  // registered, after the edge
    logic [7:0] e_sc;
    logic       e_h;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] op, ra, rb, rw,
                              input logic ua, ub, wr, br,
                              input logic pc, fi, fl, bu,
                              input logic [1:0] fa, fb,
                              input logic [7:0] sc, input logic h);
    vec_t t;
    t.v = v; t.op = op; t.ra = ra; t.rb = rb; t.rw = rw;
    t.ua = ua; t.ub = ub; t.wr = wr; t.br = br;
    t.e_pc = pc; t.e_ifid = fi; t.e_fl = fl; t.e_bub = bu;
    t.e_fa = fa; t.e_fb = fb; t.e_sc = sc; t.e_h = h;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; id_opcode = t.op; id_ra = t.ra; id_rb = t.rb;
    id_rw = t.rw; id_uses_a = t.ua; id_uses_b = t.ub; id_writes = t.wr;
    ex_branch_taken = t.br;
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = 0; id_ra = 0; id_rb = 0; id_rw = 0;
    id_uses_a = 0; id_uses_b = 0; id_writes = 0; ex_branch_taken = 0;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    @(negedge clk);
    apply(t);
    #1;
    chk("pc_we", idx, {7'd0, pc_we}, {7'd0, t.e_pc});
    chk("ifid_we", idx, {7'd0, ifid_we}, {7'd0, t.e_ifid});
    chk("ifid_flush", idx, {7'd0, ifid_flush}, {7'd0, t.e_fl});
    chk("idex_bubble", idx, {7'd0, idex_bubble}, {7'd0, t.e_bub});
    @(posedge clk);
    #1;
    chk("fwd_a", idx, {6'd0, fwd_a}, {6'd0, t.e_fa});
    chk("fwd_b", idx, {6'd0, fwd_b}, {6'd0, t.e_fb});
    chk("stall_count", idx, stall_count, t.e_sc);
    chk("halted", idx, {7'd0, halted}, {7'd0, t.e_h});
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_pc_we", idx, {7'd0, pc_we}, 8'd1);
    chk("rst_ifid_we", idx, {7'd0, ifid_we}, 8'd1);
    chk("rst_flush", idx, {7'd0, ifid_flush}, 8'd0);
    chk("rst_bubble", idx, {7'd0, idex_bubble}, 8'd0);
    chk("rst_fwd_a", idx, {6'd0, fwd_a}, 8'd0);
    chk("rst_fwd_b", idx, {6'd0, fwd_b}, 8'd0);
    chk("rst_halted", idx, {7'd0, halted}, 8'd0);
    chk("rst_stall", idx, stall_count, 8'd0);
  endtask

  // Opcodes: 1 = ALU, 8 = LOAD, F = HALT
  vec_t tv[22];

  initial begin
    //            v op  ra rb rw ua ub wr br  pc fi fl bu  fa fb sc h
    tv[0]  = mk(1, 1, 1, 2, 3, 1, 1, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0); // r3<=r1+r2
    tv[1]  = mk(1, 1, 3, 1, 4, 1, 1, 1, 0,  1, 1, 0, 0,  1, 0, 0, 0); // EX fwd
    tv[2]  = mk(1, 1, 8, 9, 7, 1, 1, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0); // independent
    tv[3]  = mk(1, 1, 6, 4, 5, 1, 1, 1, 0,  1, 1, 0, 0,  0, 2, 0, 0); // r4 in MEM -> B
    tv[4]  = mk(1, 1, 4, 1, 6, 1, 1, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0); // r4 in WB: none
    tv[5]  = mk(1, 1, 5, 6, 5, 1, 1, 1, 0,  1, 1, 0, 0,  2, 1, 0, 0); // A MEM, B EX
    tv[6]  = mk(1, 1, 5, 2, 5, 1, 1, 1, 0,  1, 1, 0, 0,  1, 0, 0, 0);
    tv[7]  = mk(1, 1, 5, 5, 2, 1, 0, 1, 0,  1, 1, 0, 0,  1, 0, 0, 0); // EX over MEM, B unused
    tv[8]  = mk(1, 8, 0, 0, 5, 0, 0, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0); // load r5
    tv[9]  = mk(1, 1, 5, 0, 6, 1, 1, 1, 0,  0, 0, 0, 1,  0, 0, 1, 0); // load-use stall
    tv[10] = mk(1, 1, 5, 0, 6, 1, 1, 1, 0,  1, 1, 0, 0,  2, 0, 1, 0); // consumer gets 10
    tv[11] = mk(0, 15, 6, 6, 6, 1, 1, 1, 0, 1, 1, 0, 0,  0, 0, 1, 0); // invalid HALT ignored
    tv[12] = mk(1, 8, 0, 0, 9, 0, 0, 1, 0,  1, 1, 0, 0,  0, 0, 1, 0); // load r9
    tv[13] = mk(1, 1, 9, 0, 1, 1, 1, 1, 1,  1, 1, 1, 1,  0, 0, 1, 0); // branch beats LU
    tv[14] = mk(1, 15, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1,  0, 0, 1, 0); // HALT squashed
    tv[15] = mk(1, 1, 2, 3, 1, 1, 1, 1, 0,  1, 1, 0, 0,  0, 0, 1, 0); // still RUN
    tv[16] = mk(1, 8, 0, 0, 4, 0, 0, 1, 0,  1, 1, 0, 0,  0, 0, 1, 0); // load r4
    tv[17] = mk(1, 15, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2, 0); // HALT waits on LU
    tv[18] = mk(1, 15, 4, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0,  2, 0, 2, 0); // HALT issues
    tv[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1,  0, 0, 2, 0); // DRAIN 1
    tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 2, 0); // DRAIN 2
    tv[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1,  0, 0, 2, 1); // DRAIN 3 -> HALTED
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    idle();
    reset = 1'b1;
    #1;
    chk_reset_vals(0);
    #11 reset = 1'b0;                      // released between edges

    for (int i = 0; i < 22; i++) begin
      run_vec(tv[i], i);
    end

    // HALTED persists regardless of branches and valid instructions.
    for (int i = 0; i < 12; i++) begin
      t = mk(1, 1, 1, 2, 3, 1, 1, 1, 1'(i % 2), 0, 0, 0, 1, 0, 0, 2, 1);
      run_vec(t, 100 + i);
    end

    // Asynchronous reset out of HALTED.
    idle();
    #1 reset = 1'b1;
    #1;
    chk_reset_vals(1);
    #1 reset = 1'b0;

    // Reset in the middle of DRAIN.
    run_vec(mk(1, 15, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 200);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 201);
    idle();
    chk("drain_pc_we", 202, {7'd0, pc_we}, 8'd0);
    reset = 1'b1;
    #1;
    chk_reset_vals(2);
    #1 reset = 1'b0;
    run_vec(mk(1, 1, 1, 2, 3, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 203);
    run_vec(mk(1, 1, 3, 1, 4, 1, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0), 204);

    // Reset in the middle of a load-use stall with stall_count at 1.
    run_vec(mk(1, 8, 0, 0, 5, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 300);
    run_vec(mk(1, 1, 5, 0, 6, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0), 301);
    run_vec(mk(1, 1, 5, 0, 6, 1, 1, 1, 0, 1, 1, 0, 0, 2, 0, 1, 0), 302);
    run_vec(mk(1, 8, 0, 0, 5, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0), 303);
    @(negedge clk);
    apply(mk(1, 1, 5, 0, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("lu_pc_we", 304, {7'd0, pc_we}, 8'd0);
    chk("lu_bubble", 304, {7'd0, idex_bubble}, 8'd1);
    reset = 1'b1;
    #1;
    chk("lu_rst_pc_we", 305, {7'd0, pc_we}, 8'd1);
    chk("lu_rst_bubble", 305, {7'd0, idex_bubble}, 8'd0);
    chk("lu_rst_stall", 305, stall_count, 8'd0);
    chk("lu_rst_fwd_a", 305, {6'd0, fwd_a}, 8'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_fwd_a", 306, {6'd0, fwd_a}, 8'd0);
    chk("post_rst_stall", 306, stall_count, 8'd0);

    // 260 load-use pairs: count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); apply(mk(1, 8, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk); apply(mk(1, 1, 5, 0, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(posedge clk);
      #1;
      if (i == 253) chk("stall_254", i, stall_count, 8'd254);
      if (i == 254) chk("stall_255", i, stall_count, 8'd255);
    end
    chk("stall_sat", 260, stall_count, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage 8-bit pipelined datapath (IF, ID, EX, MEM, WB; 16×8-bit register file; 4-bit opcode and register fields). It keeps its own record of the destination registers in flight in EX, MEM and WB. From that record it generates:
- PC and IF/ID write enables,
- ID/EX bubble insertion and IF/ID flush,
- EX-stage operand forwarding selects.

It also detects load-use hazards, squashes on taken branches, and drains the pipeline on a HALT opcode.

## Interface
Parameters:
- OP_LOAD, 4'h8, opcode of the memory load instruction
- OP_HALT, 4'hF, opcode that stops fetch and drains the pipe

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  4  opcode in ID
- id_ra, id_rb  in  4  source register A/B in ID
- id_rw  in  4  destination register in ID
- id_uses_a, id_uses_b  in  1  ID instruction reads A/B
- id_writes  in  1  ID instruction writes id_rw
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX instead of the ID instruction
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB data
- halted  out  1  pipeline stopped after HALT
- stall_count  out  8  count of load-use stall cycles

## Operation
- Tracking slots EX, MEM, WB, each holding {valid, rw, writes, is_load}. Every clock: WB<=MEM, MEM<=EX, EX<=the issued ID instruction, or an empty slot when a bubble is inserted. is_load = (id_opcode==OP_LOAD).
- An ID instruction with id_valid=0 is treated as a bubble: it raises no hazard and no HALT.
- Load-use hazard (LU): ID is valid, the EX slot is valid, writes and is_load, and the EX slot's rw equals id_ra with id_uses_a, or equals id_rb with id_uses_b.
  - Response: pc_we=0, ifid_we=0, idex_bubble=1.
  - stall_count increments and saturates at 255.
- Forwarding is computed in ID and registered with the issued instruction, so it is valid while that instruction is in EX. For operand A:
  - 01 if the EX slot writes and its rw==id_ra;
  - otherwise 10 if the MEM slot writes and its rw==id_ra;
  - otherwise 00.
  - The EX-slot match has priority.
  - Operand B uses the same rule with id_rb.
  - A select is forced to 00 when the instruction does not use that operand, and when a bubble is issued.
- A WB-stage producer needs no forwarding: the register file writes before it reads.
- Taken branch: ex_branch_taken=1 gives ifid_flush=1 and idex_bubble=1 in that cycle, with pc_we=1 and ifid_we=1 so the target is fetched.
  - The branch has priority over LU and HALT, and stall_count does not increment.
- FSM states:
  - RUN: normal operation. A valid ID instruction with opcode OP_HALT, with no branch and no LU, is issued to EX, and the FSM moves to DRAIN.
  - DRAIN: pc_we=0, ifid_we=0, idex_bubble=1. Moves to HALTED when the EX, MEM and WB slots are all empty at a clock edge, which takes 3 cycles after the HALT issues. ex_branch_taken is ignored.
  - HALTED: halted=1, pc_we=0, ifid_we=0, idex_bubble=1. The state is left only by reset.
- A HALT in ID during LU waits for the stall to clear. A HALT squashed by a branch is discarded, and the FSM stays in RUN.

## Timing
- pc_we, ifid_we, ifid_flush and idex_bubble are combinational from the current state, the slots and the ID/EX inputs, with zero latency.
- fwd_a, fwd_b, halted and stall_count are registered.
- LU stall lasts exactly 1 cycle. After it, the load is in MEM and the consumer receives fwd=10.
- Reset takes effect immediately, including mid-stall or mid-DRAIN:
  - slots cleared, state RUN;
  - fwd_a=fwd_b=00, halted=0, stall_count=0;
  - with idle inputs: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- The first edge after reset deassertion operates normally.

## Test plan
- Back-to-back ALU ops "r3<=r1+r2" then "r4<=r3+r1": second instruction gets fwd_a=01 in EX. With one independent instruction between them: fwd_a=10. With two between: fwd_a=00.
- Load r5 followed by "r6<=r5+r0": one cycle with pc_we=0, ifid_we=0, idex_bubble=1, stall_count 0->1. Next cycle the consumer issues and gets fwd_a=10 in EX.
- ex_branch_taken=1 while a dependent load-use pair sits in ID/EX: ifid_flush=1, idex_bubble=1, pc_we=1, stall_count unchanged.
- HALT (4'hF) in ID, valid: issued; DRAIN lasts 3 cycles with pc_we=0; then halted=1. halted stays 1 for 10+ further cycles with any ex_branch_taken value.
- 260 consecutive load-use stalls (load then consumer, repeated): stall_count saturates at 255.
- reset pulsed during DRAIN and again during an LU stall: all outputs return to their reset values asynchronously; normal fetch resumes on the next edge.
